// File: rtl/bmd_256_latency_drain_ctrl.sv
// ---------------------------------------------------------------------------
// bmd_256_latency_drain_ctrl
//   Drains the RX latency timestamp FIFO into the TX packet builder once the
//   FIFO raises its read trigger. Ownership of the TX engine is requested per
//   burst of up to BURST_LEN beats, and the last beat of each burst is flagged.
//   A sticky done status is held until the measurement is cleared.
//
// Ports
//   clk, rst               : clock, asynchronous active-high reset
//   latency_reset_signal   : synchronous clear; aborts any drain in progress
//   fifo_read_trigger      : FIFO full enough to start draining
//   fifo_empty, fifo_dout  : FIFO read side (1-cycle read latency)
//   fifo_rd_en             : FIFO read strobe
//   tx_req / tx_gnt        : TX engine ownership handshake
//   tx_valid/tx_ready      : beat stream handshake, tx_data/tx_last payload
//   drained_count          : entries delivered since reset (saturating)
//   busy, done             : activity / sticky completion status
// ---------------------------------------------------------------------------
module bmd_256_latency_drain_ctrl #(
  parameter int unsigned CNT_W     = 30,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned TOTAL_W   = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               latency_reset_signal,
  input  logic               fifo_read_trigger,
  input  logic               fifo_empty,
  input  logic [CNT_W-1:0]   fifo_dout,
  output logic               fifo_rd_en,
  output logic               tx_req,
  input  logic               tx_gnt,
  output logic               tx_valid,
  output logic [CNT_W-1:0]   tx_data,
  output logic               tx_last,
  input  logic               tx_ready,
  output logic [TOTAL_W-1:0] drained_count,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ,
    S_LOAD,
    S_PRESENT,
    S_DONE
  } state_e;

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  state_e               state_q, state_d;
  logic                 tx_req_q, tx_req_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 tx_last_q, tx_last_d;
  logic [CNT_W-1:0]     tx_data_q, tx_data_d;
  logic [TOTAL_W-1:0]   cnt_q, cnt_d;
  logic [7:0]           beat_q, beat_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_req_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      tx_data_q  <= '0;
      cnt_q      <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      tx_req_q   <= tx_req_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_req_d   = tx_req_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    tx_data_d  = tx_data_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;

    case (state_q)
      S_IDLE: begin
        if (fifo_read_trigger && !fifo_empty) begin
          state_d  = S_REQ;
          tx_req_d = 1'b1;
        end
      end
      S_REQ: begin
        // Re-entry from a finished burst arrives with tx_req low: raise it
        // one cycle later so the TX engine sees a gap, and ignore any grant
        // until our request is actually visible.
        if (!tx_req_q) begin
          tx_req_d = 1'b1;
        end else if (tx_gnt) begin
          beat_d = '0;
          if (fifo_empty) begin
            state_d  = S_DONE;
            tx_req_d = 1'b0;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (fifo_empty) begin
          state_d  = S_DONE;
          tx_req_d = 1'b0;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_data_d  = fifo_dout;
        tx_valid_d = 1'b1;
        tx_last_d  = (beat_q == LAST_BEAT) || fifo_empty;
        state_d    = S_PRESENT;
      end
      S_PRESENT: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + TOTAL_W'(1);
          beat_d     = beat_q + 8'd1;
          if (!tx_last_q) begin
            state_d = S_READ;
          end else begin
            tx_req_d = 1'b0;
            state_d  = fifo_empty ? S_DONE : S_REQ;
          end
        end
      end
      S_DONE: begin
      end
      default: state_d = S_IDLE;
    endcase

    if (latency_reset_signal) begin
      state_d    = S_IDLE;
      tx_req_d   = 1'b0;
      tx_valid_d = 1'b0;
      tx_last_d  = 1'b0;
      tx_data_d  = '0;
      cnt_d      = '0;
      beat_d     = '0;
    end
  end

  // Decoded from state so reset clears them without waiting for an edge.
  assign fifo_rd_en    = (state_q == S_READ) && !fifo_empty;
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign tx_req        = tx_req_q;
  assign tx_valid      = tx_valid_q;
  assign tx_last       = tx_last_q;
  assign tx_data       = tx_data_q;
  assign drained_count = cnt_q;

endmodule

// File: tb/tb_bmd_256_latency_drain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bmd_256_latency_drain_ctrl
//   Directed bench: full multi-burst drain with backpressure, abort and
//   restart, late grant with a single max-value entry, asynchronous reset in
//   the middle of a beat.
// ---------------------------------------------------------------------------
module tb_bmd_256_latency_drain_ctrl;

  localparam int unsigned CNT_W   = 30;
  localparam int unsigned TOTAL_W = 14;

  logic               clk = 1'b0;
  logic               rst;
  logic               latency_reset_signal;
  logic               fifo_read_trigger;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_dout;
  logic               fifo_rd_en;
  logic               tx_req;
  logic               tx_gnt;
  logic               tx_valid;
  logic [CNT_W-1:0]   tx_data;
  logic               tx_last;
  logic               tx_ready;
  logic [TOTAL_W-1:0] drained_count;
  logic               busy;
  logic               done;

  bmd_256_latency_drain_ctrl #(
    .CNT_W    (CNT_W),
    .BURST_LEN(16),
    .TOTAL_W  (TOTAL_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .latency_reset_signal(latency_reset_signal),
    .fifo_read_trigger   (fifo_read_trigger),
    .fifo_empty          (fifo_empty),
    .fifo_dout           (fifo_dout),
    .fifo_rd_en          (fifo_rd_en),
    .tx_req              (tx_req),
    .tx_gnt              (tx_gnt),
    .tx_valid            (tx_valid),
    .tx_data             (tx_data),
    .tx_last             (tx_last),
    .tx_ready            (tx_ready),
    .drained_count       (drained_count),
    .busy                (busy),
    .done                (done)
  );

  always #5 clk = ~clk;

  // FIFO model: common clock, one-cycle read latency, empty reflects a read
  // right after the edge that performed it.
  logic [CNT_W-1:0] mem [0:255];
  int               rd_ptr = 0;
  int               wr_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bench-side agent state.
  int               gnt_delay   = 0;
  int               wait_cnt    = 0;
  int               last_wait   = -1;
  bit               granted     = 0;
  int               rd_pre_gnt  = 0;
  int               stall_beat  = 0;
  int               stall_left  = 0;
  bit               stall_done  = 0;
  logic [CNT_W-1:0] hold_data;
  logic             hold_last;
  bit               hold_ready  = 0;
  int               abort_beat  = 0;
  bit               aborted     = 0;
  bit               req_low_chk = 0;
  int               nbeats      = 0;
  logic [CNT_W-1:0] bdata [0:63];
  logic             blast [0:63];

  task automatic push(input logic [CNT_W-1:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr++;
  endtask

  // One clock of agent activity, run at the falling edge.
  task automatic step();
    bit hs;
    @(negedge clk);
    if (latency_reset_signal) begin
      latency_reset_signal = 1'b0;
      aborted = 1;
      check_eq("clr_valid", tx_valid, 0);
      check_eq("clr_req", tx_req, 0);
      check_eq("clr_count", drained_count, 0);
      check_eq("clr_busy_done", {busy, done}, 0);
    end
    if (req_low_chk) begin
      req_low_chk = 0;
      check_eq("req_gap", tx_req, 0);
    end
    if (fifo_rd_en && (fifo_empty || tx_valid)) check_eq("rd_rule", 1, 0);
    // grant agent
    if (!tx_req) begin
      wait_cnt = 0;
      granted  = 0;
      tx_gnt   = 1'b0;
    end else if (!granted) begin
      if (fifo_rd_en) rd_pre_gnt++;
      if (wait_cnt == gnt_delay) begin
        tx_gnt    = 1'b1;
        granted   = 1;
        last_wait = wait_cnt;
      end else begin
        wait_cnt++;
      end
    end else begin
      tx_gnt = 1'b0;
    end
    // backpressure agent
    if (stall_left > 0) begin
      check_eq("stall_valid", tx_valid, 1);
      check_eq("stall_data", tx_data, hold_data);
      check_eq("stall_last", tx_last, hold_last);
      check_eq("stall_rd_en", fifo_rd_en, 0);
      stall_left--;
    end
    if (tx_valid && stall_beat != 0 && !stall_done && nbeats == stall_beat - 1) begin
      stall_done = 1;
      stall_left = 5;
      hold_data  = tx_data;
      hold_last  = tx_last;
    end
    tx_ready = (stall_left == 0) && !hold_ready;
    // abort agent
    if (abort_beat != 0 && tx_valid && nbeats == abort_beat - 1) begin
      latency_reset_signal = 1'b1;
      abort_beat = 0;
    end
    hs = tx_valid && tx_ready && !latency_reset_signal && !rst;
    if (hs) begin
      if (nbeats < 64) begin
        bdata[nbeats] = tx_data;
        blast[nbeats] = tx_last;
      end
      nbeats++;
      if (tx_last) req_low_chk = 1;
    end
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, done, 1);
  endtask

  task automatic clear_measurement();
    latency_reset_signal = 1'b1;
    step();
  endtask

  initial begin
    rst                  = 1'b1;
    latency_reset_signal = 1'b0;
    fifo_read_trigger    = 1'b0;
    tx_gnt               = 1'b0;
    tx_ready             = 1'b1;
    #1;
    check_eq("rst_ctrl", {fifo_rd_en, tx_req, tx_valid, tx_last, busy, done}, 0);
    check_eq("rst_data", tx_data, 0);
    check_eq("rst_count", drained_count, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step();

    // Full drain of 40 entries, grant after 2 cycles, stall on beat 3.
    for (int i = 1; i <= 40; i++) push(CNT_W'(i));
    gnt_delay  = 2;
    stall_beat = 3;
    nbeats     = 0;
    fifo_read_trigger = 1'b1;
    run_until_done("drain_timeout", 600);
    fifo_read_trigger = 1'b0;
    check_eq("drain_beats", nbeats, 40);
    for (int i = 0; i < 40; i++) begin
      check_eq($sformatf("drain_data%0d", i), bdata[i], i + 1);
      check_eq($sformatf("drain_last%0d", i), blast[i], (i == 15 || i == 31 || i == 39));
    end
    step();
    check_eq("drain_count", drained_count, 40);
    check_eq("drain_status", {tx_req, busy, done}, 3'b001);
    stall_beat = 0;

    // Abort on beat 7, then restart and drain the remainder.
    clear_measurement();
    for (int i = 101; i <= 120; i++) push(CNT_W'(i));
    gnt_delay  = 0;
    abort_beat = 7;
    aborted    = 0;
    nbeats     = 0;
    fifo_read_trigger = 1'b1;
    step();
    fifo_read_trigger = 1'b0;
    for (int n = 0; n < 200 && !aborted; n++) step();
    check_eq("abort_seen", aborted, 1);
    check_eq("abort_beats", nbeats, 6);
    check_eq("abort_beat6", bdata[5], 106);
    repeat (3) step();
    check_eq("abort_idle", {tx_req, busy, done}, 0);
    nbeats = 0;
    fifo_read_trigger = 1'b1;
    step();
    fifo_read_trigger = 1'b0;
    run_until_done("restart_timeout", 200);
    check_eq("restart_beats", nbeats, 13);
    for (int i = 0; i < 13; i++) begin
      check_eq($sformatf("restart_data%0d", i), bdata[i], 108 + i);
      check_eq($sformatf("restart_last%0d", i), blast[i], (i == 12));
    end
    check_eq("restart_count", drained_count, 13);

    // Late grant, single maximum-value entry, trigger held high.
    clear_measurement();
    push('1);
    gnt_delay  = 100;
    last_wait  = -1;
    rd_pre_gnt = 0;
    nbeats     = 0;
    fifo_read_trigger = 1'b1;
    run_until_done("late_timeout", 400);
    check_eq("late_wait", last_wait, 100);
    check_eq("late_rd_pre_gnt", rd_pre_gnt, 0);
    check_eq("short_beats", nbeats, 1);
    check_eq("short_data", bdata[0], 30'h3FFF_FFFF);
    check_eq("short_last", blast[0], 1);
    repeat (5) step();
    check_eq("done_sticky", {tx_req, busy, done}, 3'b001);
    check_eq("short_count", drained_count, 1);

    // Asynchronous reset while a beat is presented.
    clear_measurement();
    for (int i = 201; i <= 205; i++) push(CNT_W'(i));
    gnt_delay  = 1;
    hold_ready = 1;
    nbeats     = 0;
    for (int n = 0; n < 50 && !tx_valid; n++) step();
    check_eq("pre_rst_valid", tx_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_ctrl", {fifo_rd_en, tx_req, tx_valid, tx_last, busy, done}, 0);
    check_eq("async_data", tx_data, 0);
    check_eq("async_count", drained_count, 0);
    @(negedge clk);
    fifo_read_trigger = 1'b0;
    rst        = 1'b0;
    hold_ready = 0;
    repeat (2) step();
    check_eq("post_rst_idle", {tx_req, busy, done}, 0);
    fifo_read_trigger = 1'b1;
    step();
    fifo_read_trigger = 1'b0;
    run_until_done("post_rst_timeout", 200);
    check_eq("post_rst_beats", nbeats, 4);
    check_eq("post_rst_first", bdata[0], 202);
    check_eq("post_rst_lastval", bdata[3], 205);
    check_eq("post_rst_lastflag", {blast[0], blast[1], blast[2], blast[3]}, 4'b0001);
    check_eq("post_rst_count", drained_count, 4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/bmd_256_latency_drain_ctrl.md
Name: bmd_256_latency_drain_ctrl

Overview:
- Controller that sequences read-out of the RX-side latency timestamp FIFO (30-bit entries, 8192 deep) once that FIFO signals its read trigger.
- Requests the TX engine, drains entries in bursts of up to BURST_LEN beats over a valid/ready stream, and flags the last beat of each burst.
- Holds a done status until the latency measurement is reset.
- Sits between the timestamp FIFO (read side) and the TX packet builder.

Parameters:
- CNT_W, 30, width of one timestamp entry.
- BURST_LEN, 16, maximum beats per TX grant (range 1..255).
- TOTAL_W, 14, width of the drained-entry counter (covers 8192).

Ports:
- clk  in  1  single clock, 250 MHz.
- rst  in  1  asynchronous active-high reset.
- latency_reset_signal  in  1  synchronous clear of measurement; aborts any drain.
- fifo_read_trigger  in  1  FIFO has filled; drain may start.
- fifo_empty  in  1  FIFO empty flag (common-clock, 1-cycle read latency).
- fifo_dout  in  CNT_W  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO read strobe.
- tx_req  out  1  request for TX engine ownership.
- tx_gnt  in  1  TX grant, may arrive any cycle at or after tx_req.
- tx_valid  out  1  beat valid.
- tx_data  out  CNT_W  timestamp beat.
- tx_last  out  1  last beat of current burst.
- tx_ready  in  1  TX accepts beat when tx_valid && tx_ready.
- drained_count  out  TOTAL_W  entries delivered since last reset.
- busy  out  1  high in any state other than IDLE/DONE.
- done  out  1  drain complete; sticky.

Behaviour:
- Reset (rst asserted, async): state=IDLE; fifo_rd_en, tx_req, tx_valid, tx_last, busy, done = 0; tx_data = 0; drained_count = 0; beat counter = 0.
- latency_reset_signal (sync, higher priority than any transition): same values as reset on next edge. A beat held in the output register is discarded. An in-flight FIFO read is discarded.
- IDLE: go to REQ when fifo_read_trigger=1 and fifo_empty=0.
- REQ: tx_req=1. On tx_gnt=1 go to READ and clear the beat counter. tx_req stays high through the end of the burst and drops the cycle after the last handshake.
- READ: fifo_rd_en=1 for exactly one cycle (only if fifo_empty=0), then go to LOAD.
- LOAD:
  - Capture fifo_dout into tx_data.
  - Set tx_valid=1.
  - tx_last = (beat==BURST_LEN-1) || fifo_empty. fifo_empty sampled here already reflects the read.
  - Go to PRESENT.
- PRESENT:
  - Hold tx_valid, tx_data and tx_last stable until tx_ready=1.
  - On handshake: tx_valid=0, drained_count+1, beat+1.
  - If tx_last=0, go to READ.
  - Else if fifo_empty=1, go to DONE.
  - Else go to REQ. tx_req deasserts for at least one cycle before being re-raised.
- DONE: done=1, busy=0. Held until reset or latency_reset_signal. fifo_read_trigger is ignored here.
- Throughput: one beat per 3 cycles when tx_ready is held high.
- fifo_rd_en is never asserted while fifo_empty=1 and never while tx_valid=1.
- drained_count saturates at all-ones, with no wrap.
- fifo_read_trigger falling mid-burst is ignored; completion is governed by fifo_empty only.
- tx_gnt while not in REQ is ignored.
- If fifo_empty rises while in REQ: on tx_gnt, go directly to DONE with no beats issued, and drop tx_req.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst mid-PRESENT, then release.
  - Required: all outputs read 0 immediately, without waiting for a clock edge; state IDLE.
- Full drain, BURST_LEN=16, 40 entries (values 1..40), tx_gnt 2 cycles after tx_req, tx_ready=1:
  - Required: bursts of 16, 16 and 8 beats.
  - tx_last on values 16, 32 and 40.
  - tx_req drops between bursts.
  - done=1 and drained_count=40 at the end.
- Backpressure:
  - Stimulus: tx_ready low for 5 cycles on beat 3.
  - Required: tx_data and tx_last stable across the stall; no fifo_rd_en during the stall; order preserved.
- Abort:
  - Stimulus: pulse latency_reset_signal on beat 7 of the first burst.
  - Required: next cycle tx_valid=0, tx_req=0, drained_count=0, state IDLE.
  - A new fifo_read_trigger restarts cleanly.
- Short FIFO:
  - Stimulus: 1 entry (value 0x3FFFFFFF), trigger forced high.
  - Required: one beat with tx_last=1, tx_data=0x3FFFFFFF, then done.
- Late grant:
  - Stimulus: tx_gnt held off 100 cycles.
  - Required: tx_req held high for the whole wait; no fifo_rd_en before the grant.
